// File: rtl/fmul_dispatch_pkg.sv
// fmul_dispatch_pkg: multiplier opcode/rounding encodings and default pipeline depth
// shared by the dispatcher, its bus interface and the result buffer.
package fmul_dispatch_pkg;
   localparam int LATENCY = 2;
   localparam int OPC_W = 2;
   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RDN = 2'd2,
      RM_RUP = 2'd3
   } rmode_e;
   typedef enum logic [OPC_W-1:0] {
      OPC_MUL   = 2'd0,
      OPC_INV_S = 2'd1,
      OPC_ABS_W = 2'd2,
      OPC_IDLE  = 2'd3
   } opc_e;
endpackage

// File: rtl/fmul_dispatch_if.sv
// fmul_dispatch_if: request, multiplier-drive and result channels of the dispatcher;
// slave is the dispatcher side, master the requester/multiplier/consumer side.
interface fmul_dispatch_if
   import fmul_dispatch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OPC_W  = fmul_dispatch_pkg::OPC_W,
   parameter int TAG_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_op1;
   logic [DATA_W-1:0] in_op2;
   logic [OPC_W-1:0]  in_opc;
   logic [1:0]        in_rmode;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] mul_op1;
   logic [DATA_W-1:0] mul_op2;
   logic [OPC_W-1:0]  mul_opc;
   logic [1:0]        mul_rmode;
   logic [31:0]       mul_result;
   logic              mul_val;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_result;
   logic              out_flag;
   logic [TAG_W-1:0]  out_tag;
   logic              busy;
   modport slave (
      input  in_valid, in_op1, in_op2, in_opc, in_rmode, in_tag, mul_result, mul_val, out_ready,
      output in_ready, mul_op1, mul_op2, mul_opc, mul_rmode, out_valid, out_result, out_flag,
             out_tag, busy
   );
   modport master (
      output in_valid, in_op1, in_op2, in_opc, in_rmode, in_tag, mul_result, mul_val, out_ready,
      input  in_ready, mul_op1, mul_op2, mul_opc, mul_rmode, out_valid, out_result, out_flag,
             out_tag, busy
   );
endinterface

// File: rtl/fmul_dispatch_result_fifo.sv
// result_fifo: power-of-two circular result buffer with occupancy count and full/empty flags.
// Storage is not reset; only pointers and count are.
module result_fifo
   import fmul_dispatch_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           din_i,
   output logic [W-1:0]           dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   always_comb begin
      wr_d  = wr_q + AW'(push_i);
      rd_d  = rd_q + AW'(pop_i);
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/fmul_dispatch.sv
// fmul_dispatch: credit-based issue to a fixed-latency, non-stallable multiplier,
// tracking in-flight tags and buffering results in order for the consumer.
module fmul_dispatch
   import fmul_dispatch_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int OPERATION_NUM = 4,
   parameter int TAG_W         = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int LATENCY       = fmul_dispatch_pkg::LATENCY
) (
   input logic           clk,
   input logic           rst,
   fmul_dispatch_if.slave bus
);
   localparam int OW = $clog2(OPERATION_NUM);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 32 + 1 + TAG_W;
   logic [LATENCY-1:0]            vld_q, vld_d;
   logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
   logic                          issue, push, pop, full, empty;
   logic [AW:0]                   cnt;
   logic [EW-1:0]                 head;
   int                            infl;
   assign infl         = $countones(vld_q);
   // Credit reserves a buffer slot per in-flight request since results cannot be stalled.
   assign bus.in_ready = (int'(cnt) + infl) < FIFO_DEPTH;
   assign issue        = bus.in_valid & bus.in_ready;
   assign push         = vld_q[LATENCY-1];
   assign pop          = bus.out_valid & bus.out_ready;
   always_comb begin
      bus.mul_op1   = issue ? bus.in_op1 : {DATA_W{1'b0}};
      bus.mul_op2   = issue ? bus.in_op2 : {DATA_W{1'b0}};
      bus.mul_opc   = issue ? bus.in_opc : {OW{1'b0}};
      bus.mul_rmode = issue ? bus.in_rmode : 2'b00;
   end
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = issue;
      tag_d    = tag_q << TAG_W;
      tag_d[0] = bus.in_tag;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end
   result_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (pop),
      .din_i  ({bus.mul_result, bus.mul_val, tag_q[LATENCY-1]}),
      .dout_o (head),
      .full_o (full),
      .empty_o(empty),
      .count_o(cnt)
   );
   assign {bus.out_result, bus.out_flag, bus.out_tag} = head;
   assign bus.out_valid = ~empty;
   assign bus.busy      = (|vld_q) | ~empty;
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: tb/tb_fmul_dispatch.sv
// tb_fmul_dispatch: directed checks of issue, credit back-pressure, ordering, reset and wrap.
// A stub two-stage multiplier model sits on the mul_* side of the bus.
module tb_fmul_dispatch;
   import fmul_dispatch_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n, k;
   logic [32:0] p1, p2;
   logic [3:0]  q_tag[$];
   logic [31:0] q_res[$];
   logic        q_flag[$];
   int          q_cyc[$];
   int          ff_exp[6] = '{2, 2, 2, 1, 1, 1};
   fmul_dispatch_if #(.DATA_W(32), .OPC_W(2), .TAG_W(4)) bus ();
   fmul_dispatch #(.DATA_W(32), .OPERATION_NUM(4), .TAG_W(4), .FIFO_DEPTH(4), .LATENCY(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   // Stub multiplier: exponent-domain add, exact when mantissas are zero (1.0*2.0 = 2.0).
   function automatic logic [32:0] mul_model(logic [31:0] a, logic [31:0] b, logic [1:0] opc);
      return opc == OPC_MUL   ? {a[31] ^ b[31], a[30:0] + b[30:0] - 31'h3F800000, 1'b1} :
             opc == OPC_INV_S ? {a ^ 32'h80000000, 1'b1} :
             opc == OPC_ABS_W ? {1'b0, a[30:0], 1'b1} : 33'd0;
   endfunction
   always @(posedge clk) begin
      p1 <= mul_model(bus.mul_op1, bus.mul_op2, bus.mul_opc);
      p2 <= p1;
   end
   assign bus.mul_result = p2[32:1];
   assign bus.mul_val    = p2[0];
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         q_tag.push_back(bus.out_tag);
         q_res.push_back(bus.out_result);
         q_flag.push_back(bus.out_flag);
         q_cyc.push_back(cyc);
      end
   end
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic clear();
      q_tag.delete();
      q_res.delete();
      q_flag.delete();
      q_cyc.delete();
   endtask
   task automatic wait_n(int num, int lim);
      for (int c = 0; c < lim && q_tag.size() < num; c++) step();
      chk("drain_cnt", 64'(q_tag.size()), 64'(num));
   endtask
   task automatic chk_tags(string tag, int num);
      for (int i = 0; i < num && i < q_tag.size(); i++) chk(tag, 64'(q_tag[i]), 64'(i));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
   initial begin
      bus.in_valid = 0;
      bus.in_op1 = '0;
      bus.in_op2 = '0;
      bus.in_opc = OPC_MUL;
      bus.in_rmode = RM_RNE;
      bus.in_tag = '0;
      bus.out_ready = 0;
      step();
      step();
      chk("rst_rdy", 64'(bus.in_ready), 1);
      chk("rst_ov", 64'(bus.out_valid), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_mul", 64'(bus.mul_op1), 0);
      // Single request issued in the very first cycle after reset release.
      rst = 0;
      bus.in_valid = 1;
      bus.in_op1 = 32'h3F800000;
      bus.in_op2 = 32'h40000000;
      bus.in_opc = OPC_MUL;
      bus.in_rmode = RM_RTZ;
      bus.in_tag = 4'd5;
      #1;
      chk("iss_op1", 64'(bus.mul_op1), 64'h3F800000);
      chk("iss_op2", 64'(bus.mul_op2), 64'h40000000);
      chk("iss_rm", 64'(bus.mul_rmode), 64'(RM_RTZ));
      step();
      bus.in_valid = 0;
      #1;
      chk("idle_mul", 64'(bus.mul_op1), 0);
      chk("idle_rm", 64'(bus.mul_rmode), 0);
      chk("e0_ov", 64'(bus.out_valid), 0);
      chk("e0_busy", 64'(bus.busy), 1);
      step();
      chk("e1_ov", 64'(bus.out_valid), 0);
      step();
      chk("e2_ov", 64'(bus.out_valid), 1);
      chk("e2_res", 64'(bus.out_result), 64'h40000000);
      chk("e2_tag", 64'(bus.out_tag), 5);
      chk("e2_flag", 64'(bus.out_flag), 1);
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      #1;
      chk("pop_ov", 64'(bus.out_valid), 0);
      chk("pop_busy", 64'(bus.busy), 0);
      // Back-to-back stream of eight.
      clear();
      bus.out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1;
         bus.in_tag = 4'(i);
         bus.in_op1 = 32'(i);
         bus.in_op2 = 32'h3F800000;
         bus.in_opc = OPC_MUL;
         #1;
         chk("st_rdy", 64'(bus.in_ready), 1);
         step();
      end
      bus.in_valid = 0;
      wait_n(8, 20);
      chk_tags("st_tag", 8);
      for (int i = 0; i < 8 && i < q_tag.size(); i++) begin
         chk("st_res", 64'(q_res[i]), 64'(i));
         if (i > 0) chk("st_cyc", 64'(q_cyc[i] - q_cyc[i-1]), 1);
      end
      // Back-pressure: four credits, then a single pop frees exactly one.
      clear();
      bus.out_ready = 0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1;
         bus.in_tag = 4'(n);
         #1;
         if (bus.in_ready) n++;
         step();
      end
      chk("bp_iss", 64'(n), 4);
      chk("bp_rdy", 64'(bus.in_ready), 0);
      bus.out_ready = 1;
      #1;
      chk("bp_rdy_pop", 64'(bus.in_ready), 0);
      step();
      bus.out_ready = 0;
      #1;
      chk("bp_rdy_after", 64'(bus.in_ready), 1);
      for (int c = 0; c < 5; c++) begin
         bus.in_tag = 4'(n);
         #1;
         if (bus.in_ready) n++;
         step();
      end
      chk("bp_iss2", 64'(n), 5);
      chk("bp_rdy2", 64'(bus.in_ready), 0);
      bus.in_valid = 0;
      bus.out_ready = 1;
      wait_n(5, 20);
      chk_tags("bp_tag", 5);
      // Write and pop in the same edge once the buffer is saturated.
      clear();
      bus.out_ready = 0;
      n = 0;
      for (int c = 0; c < 10 && n < 4; c++) begin
         bus.in_valid = 1;
         bus.in_tag = 4'(n);
         #1;
         if (bus.in_ready) n++;
         step();
      end
      bus.out_ready = 1;
      for (int c = 0; c < 6; c++) begin
         bus.in_tag = 4'(n);
         #1;
         chk("ff_cnt", 64'(dut.u_fifo.cnt_q), 64'(ff_exp[c]));
         if (bus.in_ready) n++;
         step();
      end
      chk("ff_iss", 64'(n), 9);
      bus.in_valid = 0;
      wait_n(9, 30);
      chk_tags("ff_tag", 9);
      // Reset with two requests in flight discards them.
      clear();
      bus.out_ready = 0;
      bus.in_valid = 1;
      bus.in_tag = 4'd1;
      step();
      bus.in_tag = 4'd2;
      step();
      bus.in_valid = 0;
      step();
      rst = 1;
      #1;
      chk("ar_ov", 64'(bus.out_valid), 0);
      chk("ar_busy", 64'(bus.busy), 0);
      chk("ar_rdy", 64'(bus.in_ready), 1);
      step();
      step();
      rst = 0;
      bus.out_ready = 1;
      for (int c = 0; c < 5; c++) step();
      chk("ar_none", 64'(q_tag.size()), 0);
      bus.in_valid = 1;
      bus.in_tag = 4'd9;
      bus.in_op1 = 32'h00000007;
      bus.in_opc = OPC_ABS_W;
      step();
      bus.in_valid = 0;
      wait_n(1, 10);
      for (int c = 0; c < 4; c++) step();
      chk("ar_one", 64'(q_tag.size()), 1);
      if (q_tag.size() > 0) chk("ar_tag9", 64'(q_tag[0]), 9);
      // Pointer wrap with a randomly stalling consumer.
      clear();
      k = 0;
      for (int c = 0; c < 400 && k < 12; c++) begin
         bus.in_valid = 1;
         bus.in_tag = 4'(k);
         bus.in_op1 = 32'(k);
         bus.in_op2 = 32'h3F800000;
         bus.in_opc = 2'(k % 4);
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         if (bus.in_ready) k++;
         step();
      end
      chk("wr_iss", 64'(k), 12);
      bus.in_valid = 0;
      for (int c = 0; c < 400 && q_tag.size() < 12; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         step();
      end
      chk("wr_cnt", 64'(q_tag.size()), 12);
      chk_tags("wr_tag", 12);
      for (int i = 0; i < 12 && i < q_tag.size(); i++) begin
         chk("wr_flag", 64'(q_flag[i]), 64'(i % 4 != 3));
         chk("wr_res", 64'(q_res[i]),
             i % 4 == 1 ? 64'(32'(i) ^ 32'h80000000) : i % 4 == 3 ? 64'd0 : 64'(i));
      end
      chk("wr_busy", 64'(bus.busy), 0);
      chk("wr_ov", 64'(bus.out_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
